// File: rtl/proc_run_ctrl.sv
// Run controller: streams a program into imem, holds the processor in reset, runs it until halt or watchdog expiry.
// Optional PROC_RUN_CTRL_SINGLE_STEP_EN adds a step input that gates proc_en to one cycle per step cycle.
module proc_run_ctrl #(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              proc_rst,
    output logic              proc_en,
`ifdef PROC_RUN_CTRL_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              halt_in,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]    TO_VAL  = (CNT_W+1)'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RSTHOLD, S_RUN, S_HALTED, S_TIMEDOUT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic [CNT_W-1:0]  cnt_n, cnt_inc;
    logic              xfer, active;
    logic              proc_rst_n, proc_en_n, busy_n, done_n, timed_out_n;

    assign load_ready = (state == S_LOAD);
    assign xfer       = load_valid && load_ready;
    assign imem_we    = xfer;
    assign imem_addr  = ptr;
    assign imem_wdata = load_data;

    // Only cycles in which the processor was actually enabled are counted and evaluated.
    assign active  = (state == S_RUN) && proc_en;
    assign cnt_inc = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold;
        cnt_n   = cycle_count;
        case (state)
            S_IDLE, S_HALTED, S_TIMEDOUT: begin
                if (start) begin
                    state_n = S_LOAD;
                    ptr_n   = '0;
                    cnt_n   = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (ptr != PTR_MAX) ptr_n = ptr + 1'b1;
                    if (load_last || ptr == PTR_MAX) begin
                        state_n = S_RSTHOLD;
                        hold_n  = '0;
                    end
                end
            end
            S_RSTHOLD: begin
                if (hold == HOLD_LAST) state_n = S_RUN;
                else                   hold_n  = hold + 1'b1;
            end
            S_RUN: begin
                if (active) begin
                    cnt_n = cnt_inc;
                    if (halt_in)
                        state_n = S_HALTED;
                    else if (TIMEOUT != 0 && {1'b0, cnt_inc} == TO_VAL)
                        state_n = S_TIMEDOUT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        proc_rst_n  = (state_n == S_IDLE) || (state_n == S_LOAD) || (state_n == S_RSTHOLD);
`ifdef PROC_RUN_CTRL_SINGLE_STEP_EN
        proc_en_n   = (state_n == S_RUN) && step;
`else
        proc_en_n   = (state_n == S_RUN);
`endif
        busy_n      = (state_n == S_LOAD) || (state_n == S_RSTHOLD) || (state_n == S_RUN);
        done_n      = (state_n == S_HALTED) || (state_n == S_TIMEDOUT);
        timed_out_n = (state_n == S_TIMEDOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            hold        <= '0;
            cycle_count <= '0;
            proc_rst    <= 1'b1;
            proc_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hold        <= hold_n;
            cycle_count <= cnt_n;
            proc_rst    <= proc_rst_n;
            proc_en     <= proc_en_n;
            busy        <= busy_n;
            done        <= done_n;
            timed_out   <= timed_out_n;
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Randomized run-level bench for proc_run_ctrl with a transaction-level expectation model.
module tb_proc_run_ctrl;

    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 2;
    localparam int RST_CYCLES = 2;
    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 10;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              proc_rst;
    logic              proc_en;
    logic              halt_in;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_count;
`ifdef PROC_RUN_CTRL_SINGLE_STEP_EN
    logic              step = 1'b1;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] words[$];

    proc_run_ctrl #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .proc_rst(proc_rst), .proc_en(proc_en),
`ifdef PROC_RUN_CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .halt_in(halt_in), .busy(busy), .done(done), .timed_out(timed_out),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run: start, stream the words queue, hold, run until halt cycle h (0 = never).
    task automatic do_run(input int gaps, input bit use_last, input int h);
        int n, e, cnt, lim;
        bit lst;
        n   = words.size();
        e   = (n < DEPTH) ? n : DEPTH;
        lst = use_last || (n < DEPTH);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        check("start_busy", busy, 1);
        check("start_cnt", cycle_count, 0);
        check("start_done", done, 0);
        check("start_to", timed_out, 0);
        check("start_rdy", load_ready, 1);
        for (int i = 0; i < e; i++) begin
            if ((gaps == 1 && i > 0) || (gaps == 2 && ($urandom % 2) == 1)) begin
                load_valid = 1'b0; halt_in = 1'($urandom % 2); #1;
                check("gap_we", imem_we, 0);
                check("gap_rdy", load_ready, 1);
                @(negedge clk);
            end
            load_valid = 1'b1; load_data = words[i];
            load_last  = lst && (i == n - 1);
            halt_in    = 1'($urandom % 2); #1;
            check("ld_we", imem_we, 1);
            check("ld_addr", imem_addr, i);
            check("ld_data", imem_wdata, words[i]);
            @(negedge clk);
        end
        // Surplus words stay offered during the hold and must never be written.
        load_valid = (n > e); load_data = (n > e) ? words[e] : '0; load_last = 1'b0; #1;
        cnt = 0;
        while (!proc_en && cnt < 20) begin
            check("hold_rst", proc_rst, 1);
            check("hold_we", imem_we, 0);
            check("hold_rdy", load_ready, 0);
            cnt++;
            @(negedge clk); halt_in = 1'($urandom % 2); #1;
        end
        check("hold_len", cnt, RST_CYCLES);
        load_valid = 1'b0;
        lim = (h > 0 && h <= TIMEOUT) ? h : TIMEOUT;
        for (int k = 1; k <= lim; k++) begin
            check("run_en", proc_en, 1);
            check("run_rst", proc_rst, 0);
            check("run_cnt", cycle_count, k - 1);
            check("run_done", done, 0);
            halt_in = (k == h);
            start   = (($urandom % 4) == 0);
            @(negedge clk); #1;
        end
        halt_in = 1'b0; start = 1'b0;
        check("end_done", done, 1);
        check("end_to", timed_out, (h == 0 || h > TIMEOUT) ? 1 : 0);
        check("end_cnt", cycle_count, lim);
        check("end_en", proc_en, 0);
        check("end_rst", proc_rst, 0);
        check("end_busy", busy, 0);
        repeat (2) begin
            @(negedge clk); halt_in = 1'($urandom % 2); #1;
            check("idle_cnt", cycle_count, lim);
            check("idle_done", done, 1);
        end
        halt_in = 1'b0;
    endtask

    initial begin
        int cnt, n;
        rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
        load_last = 1'b0; halt_in = 1'b0;
        #1;
        check("rst_prst", proc_rst, 1);
        check("rst_en", proc_en, 0);
        check("rst_done", done, 0);
        check("rst_to", timed_out, 0);
        check("rst_cnt", cycle_count, 0);
        check("rst_rdy", load_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b0;

        words = '{32'h8C010005, 32'h00000000, 32'hFC000000};
        do_run(0, 1'b1, 5);
        do_run(1, 1'b1, 0);
        words = '{32'h12345678};
        do_run(0, 1'b1, TIMEOUT);
        words = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
        do_run(0, 1'b0, 3);
        words = '{32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004};
        do_run(2, 1'b0, 1);

        for (int r = 0; r < 12; r++) begin
            words.delete();
            n = 1 + int'($urandom % 6);
            for (int i = 0; i < n; i++) words.push_back($urandom);
            do_run(int'($urandom % 3), 1'($urandom % 2), int'($urandom % 14));
        end

        // Reset in the middle of a run.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        load_valid = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b1;
        @(negedge clk); load_valid = 1'b0; load_last = 1'b0;
        cnt = 0;
        while (!proc_en && cnt < 20) begin
            @(negedge clk); cnt++;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1; #1;
        check("mrst_prst", proc_rst, 1);
        check("mrst_en", proc_en, 0);
        check("mrst_done", done, 0);
        check("mrst_cnt", cycle_count, 0);
        check("mrst_busy", busy, 0);
        check("mrst_rdy", load_ready, 0);
        @(negedge clk); rst = 1'b0;

        // Reset in the middle of a load write.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        load_valid = 1'b1; load_data = 32'hCAFEF00D; #1;
        check("mld_we_pre", imem_we, 1);
        #1 rst = 1'b1; #1;
        check("mld_we", imem_we, 0);
        check("mld_rdy", load_ready, 0);
        load_valid = 1'b0;
        @(negedge clk); rst = 1'b0;

        words = '{32'h11111111, 32'h22222222};
        do_run(0, 1'b1, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
